// File: rtl/count_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// count_sequencer
//
// Command-driven controller for an up/down count datapath. Owns the count
// register, the shadow and active limit registers and the terminal logic.
// The count advances only on the one-cycle TICK strobe. START/STOP/LOAD
// commands arrive over a valid/ready handshake and sequence one-shot or
// periodic runs. Every terminal event produces a one-cycle DONE pulse and
// bumps a saturating EVENTS counter.
//
// Ports
//   CLK        in   1      system clock, all logic on posedge
//   RST        in   1      synchronous, active-low reset
//   TICK       in   1      count-enable strobe, one CLK wide
//   CMD_VALID  in   1      command valid
//   CMD_READY  out  1      command ready (low only in FIN)
//   CMD_OP     in   2      00 NOP, 01 START, 10 STOP, 11 LOAD
//   CMD_DATA   in   WIDTH  LOAD: new shadow limit
//   CMD_DIR    in   1      START: 0 = up, 1 = down
//   CMD_MODE   in   1      START: 0 = one-shot, 1 = periodic
//   CNT        out  WIDTH  current count
//   CNT_DIR    out  1      direction latched at START
//   BUSY       out  1      high in RUN or FIN
//   DONE       out  1      one-cycle pulse per terminal event
//   EVENTS     out  EVW    saturating terminal-event count since START from IDLE
// ---------------------------------------------------------------------------
module count_sequencer #(
   parameter int WIDTH = 19,
   parameter int EVW   = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             TICK,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [1:0]       CMD_OP,
   input  logic [WIDTH-1:0] CMD_DATA,
   input  logic             CMD_DIR,
   input  logic             CMD_MODE,
   output logic [WIDTH-1:0] CNT,
   output logic             CNT_DIR,
   output logic             BUSY,
   output logic             DONE,
   output logic [EVW-1:0]   EVENTS
);

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_START = 2'b01;
   localparam logic [1:0] OP_STOP  = 2'b10;
   localparam logic [1:0] OP_LOAD  = 2'b11;

   // Reset limit is the largest value with the top bit clear.
   localparam logic [WIDTH-1:0] LIM_RST = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [EVW-1:0]   EV_MAX  = {EVW{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_HOLD = 2'b10,
      S_FIN  = 2'b11
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             r_dir;
   logic             w_dir_nxt;
   logic             r_mode;
   logic             w_mode_nxt;
   logic [WIDTH-1:0] r_lim_sh;
   logic [WIDTH-1:0] w_lim_sh_nxt;
   logic [WIDTH-1:0] r_act_lim;
   logic [WIDTH-1:0] w_act_lim_nxt;
   logic [EVW-1:0]   r_events;
   logic [EVW-1:0]   w_events_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_ready;
   logic             r_busy;

   logic             w_accept;
   logic             w_start;
   logic             w_stop;
   logic             w_load;
   logic             w_terminal;
   logic [EVW-1:0]   w_events_inc;

   // Handshake decode; READY is registered so acceptance follows the state.
   always_comb begin
      w_accept = CMD_VALID & r_ready;
      w_start  = w_accept & (CMD_OP == OP_START);
      w_stop   = w_accept & (CMD_OP == OP_STOP);
      w_load   = w_accept & (CMD_OP == OP_LOAD);
   end

   // Terminal condition for the current direction, and saturating increment.
   always_comb begin
      if (r_dir) begin
         w_terminal = (r_cnt == {WIDTH{1'b0}});
      end else begin
         w_terminal = (r_cnt == r_act_lim);
      end
      if (r_events != EV_MAX) begin
         w_events_inc = r_events + EVW'(1);
      end else begin
         w_events_inc = r_events;
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-datapath logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_dir_nxt     = r_dir;
      w_mode_nxt    = r_mode;
      w_act_lim_nxt = r_act_lim;
      w_events_nxt  = r_events;
      w_done_nxt    = 1'b0;

      // LOAD only touches the shadow limit, so it never disturbs a run.
      if (w_load) begin
         w_lim_sh_nxt = CMD_DATA;
      end else begin
         w_lim_sh_nxt = r_lim_sh;
      end

      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_cnt_nxt     = CMD_DIR ? r_lim_sh : {WIDTH{1'b0}};
               w_dir_nxt     = CMD_DIR;
               w_mode_nxt    = CMD_MODE;
               w_act_lim_nxt = r_lim_sh;
               w_events_nxt  = {EVW{1'b0}};
               w_state_nxt   = S_RUN;
            end else begin
               w_state_nxt   = S_IDLE;
            end
         end
         S_RUN: begin
            // An accepted START/STOP takes priority; a coincident TICK is lost.
            if (w_start) begin
               w_cnt_nxt     = CMD_DIR ? r_lim_sh : {WIDTH{1'b0}};
               w_dir_nxt     = CMD_DIR;
               w_mode_nxt    = CMD_MODE;
               w_act_lim_nxt = r_lim_sh;
               w_state_nxt   = S_RUN;
            end else if (w_stop) begin
               w_state_nxt   = S_HOLD;
            end else if (TICK) begin
               if (w_terminal) begin
                  w_done_nxt   = 1'b1;
                  w_events_nxt = w_events_inc;
                  if (r_mode) begin
                     // Periodic: wrap to the starting value on the same edge.
                     w_cnt_nxt   = r_dir ? r_act_lim : {WIDTH{1'b0}};
                     w_state_nxt = S_RUN;
                  end else begin
                     w_state_nxt = S_FIN;
                  end
               end else if (r_dir) begin
                  w_cnt_nxt = r_cnt - WIDTH'(1);
               end else begin
                  w_cnt_nxt = r_cnt + WIDTH'(1);
               end
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_HOLD: begin
            if (w_start) begin
               w_state_nxt = S_RUN;
            end else if (w_stop) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_HOLD;
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath and registered output flags.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_cnt     <= {WIDTH{1'b0}};
         r_dir     <= 1'b0;
         r_mode    <= 1'b0;
         r_lim_sh  <= LIM_RST;
         r_act_lim <= LIM_RST;
         r_events  <= {EVW{1'b0}};
         r_done    <= 1'b0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_dir     <= w_dir_nxt;
         r_mode    <= w_mode_nxt;
         r_lim_sh  <= w_lim_sh_nxt;
         r_act_lim <= w_act_lim_nxt;
         r_events  <= w_events_nxt;
         r_done    <= w_done_nxt;
         r_ready   <= (w_state_nxt != S_FIN);
         r_busy    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_FIN);
      end
   end

   assign CMD_READY = r_ready;
   assign CNT       = r_cnt;
   assign CNT_DIR   = r_dir;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign EVENTS    = r_events;

endmodule
